// File: rtl/instr_link_pkg.sv
// Shared types and helpers for the instruction-byte link.
// IR_CHECKSUM_EN adds an XOR checksum beat per word.
package instr_link_pkg;

   localparam int BYTE_W_DEF = 8;
   localparam int NBYTES_DEF = 3;
   localparam int WORD_W_DEF = BYTE_W_DEF * NBYTES_DEF;
   localparam int MAX_W      = 64;

   typedef enum logic {
      IDLE,
      SEND
   } state_t;

   // XOR of the nbytes low byte lanes of w, result in the low byte lane
   function automatic logic [MAX_W-1:0] xor_bytes(
      input logic [MAX_W-1:0] w,
      input int               byte_w,
      input int               nbytes
   );
      logic [MAX_W-1:0] acc;
      logic [MAX_W-1:0] mask;
      acc  = '0;
      mask = {MAX_W{1'b1}} >> (MAX_W - byte_w);
      for (int i = 0; i < nbytes; i++)
         acc = acc ^ ((w >> (i * byte_w)) & mask);
      return acc;
   endfunction

endpackage

// File: rtl/instr_word_slot.sv
// One word register with a valid bit.
// Clear wins over load.
module instr_word_slot #(
   parameter int W = 24
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic         clear,
   input  logic [W-1:0] d,
   output logic [W-1:0] q,
   output logic         valid
);

   // hold a word until cleared or replaced
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q     <= '0;
         valid <= 1'b0;
      end else if (clear) begin
         q     <= '0;
         valid <= 1'b0;
      end else if (load) begin
         q     <= d;
         valid <= 1'b1;
      end
   end

endmodule

// File: rtl/instr_byte_serializer.sv
// Word-to-byte serializer, MSB byte first, one pending word.
// IR_CHECKSUM_EN appends an XOR checksum beat per word.
module instr_byte_serializer
   import instr_link_pkg::*;
#(
   parameter int BYTE_W = BYTE_W_DEF,
   parameter int NBYTES = NBYTES_DEF,
   parameter int CNT_W  = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [BYTE_W*NBYTES-1:0] in_word,
   input  logic                     flush,
   output logic [BYTE_W-1:0]        payload,
   output logic                     IR_load,
   input  logic                     out_ready,
   output logic                     out_last,
   output logic                     busy,
   output logic [CNT_W-1:0]         words_sent
);

   localparam int WORD_W = BYTE_W * NBYTES;
`ifdef IR_CHECKSUM_EN
   localparam int NBEATS = NBYTES + 1;
`else
   localparam int NBEATS = NBYTES;
`endif
   localparam int IDX_W = (NBEATS > 1) ? $clog2(NBEATS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBEATS - 1);

   state_t            state;
   logic [IDX_W-1:0]  idx;
   logic [CNT_W-1:0]  cnt;

   logic              act_load;
   logic              act_clear;
   logic [WORD_W-1:0] act_d;
   logic [WORD_W-1:0] act_q;
   logic              act_valid;
   logic              pend_load;
   logic              pend_clear;
   logic [WORD_W-1:0] pend_q;
   logic              pend_valid;

   logic              accept;
   logic              beat;
   logic              last_beat;
   logic [BYTE_W-1:0] data_byte;

   instr_word_slot #(.W(WORD_W)) u_active (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (act_load),
      .clear (act_clear),
      .d     (act_d),
      .q     (act_q),
      .valid (act_valid)
   );

   instr_word_slot #(.W(WORD_W)) u_pending (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (pend_load),
      .clear (pend_clear),
      .d     (in_word),
      .q     (pend_q),
      .valid (pend_valid)
   );

   assign in_ready   = !pend_valid;
   assign accept     = in_valid && in_ready;
   assign IR_load    = (state == SEND);
   assign busy       = act_valid;
   assign beat       = IR_load && out_ready;
   assign last_beat  = beat && (idx == LAST_IDX);
   assign words_sent = cnt;
   assign payload    = IR_load ? data_byte : '0;
   assign out_last   = IR_load && (idx == LAST_IDX);

`ifdef IR_CHECKSUM_EN
   logic [BYTE_W-1:0] chk;
   assign chk = BYTE_W'(xor_bytes(MAX_W'(act_q), BYTE_W, NBYTES));
`endif

   // pick the byte lane addressed by idx, idx 0 = MSB lane
   always_comb begin
      data_byte = '0;
      for (int i = 0; i < NBYTES; i++) begin
         if (idx == IDX_W'(i))
            data_byte = act_q[(NBYTES-1-i)*BYTE_W +: BYTE_W];
      end
`ifdef IR_CHECKSUM_EN
      if (idx == IDX_W'(NBYTES))
         data_byte = chk;
`endif
   end

   // steer words between input, pending and active slots
   always_comb begin
      act_load   = 1'b0;
      act_clear  = 1'b0;
      act_d      = in_word;
      pend_load  = 1'b0;
      pend_clear = 1'b0;
      if (flush) begin
         act_clear  = 1'b1;
         pend_clear = 1'b1;
      end else if (state == IDLE) begin
         act_load = accept;
      end else if (last_beat) begin
         if (pend_valid) begin
            act_load   = 1'b1;
            act_d      = pend_q;
            pend_clear = 1'b1;
         end else if (accept) begin
            act_load = 1'b1;
         end else begin
            act_clear = 1'b1;
         end
      end else begin
         pend_load = accept;
      end
   end

   // sequencing FSM, byte index and completed-word counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         idx   <= '0;
         cnt   <= '0;
      end else begin
         if (last_beat)
            cnt <= cnt + 1'b1;
         if (flush) begin
            state <= IDLE;
            idx   <= '0;
         end else begin
            unique case (state)
               IDLE: begin
                  if (accept) begin
                     state <= SEND;
                     idx   <= '0;
                  end
               end
               SEND: begin
                  if (last_beat) begin
                     idx <= '0;
                     if (!pend_valid && !accept)
                        state <= IDLE;
                  end else if (beat) begin
                     idx <= idx + 1'b1;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_instr_byte_serializer.sv
// Scoreboard bench for instr_byte_serializer.
// Honours IR_CHECKSUM_EN when defined.
module tb_instr_byte_serializer;

   localparam int NB = 3;
   localparam int WW = 24;
`ifdef IR_CHECKSUM_EN
   localparam bit CHK_ON = 1'b1;
   localparam int NBEATS = NB + 1;
`else
   localparam bit CHK_ON = 1'b0;
   localparam int NBEATS = NB;
`endif

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic          flush = 1'b0;
   logic          out_ready = 1'b0;
   logic [WW-1:0] in_word = '0;
   logic          in_ready;
   logic          IR_load;
   logic          out_last;
   logic          busy;
   logic [7:0]    payload;
   logic [7:0]    words_sent;

   int            passed = 0;
   int            total = 0;
   logic [8:0]    expq[$];
   logic [7:0]    exp_ws = '0;

   always #5 clk = ~clk;

   instr_byte_serializer dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_word    (in_word),
      .flush      (flush),
      .payload    (payload),
      .IR_load    (IR_load),
      .out_ready  (out_ready),
      .out_last   (out_last),
      .busy       (busy),
      .words_sent (words_sent)
   );

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // reference: a word becomes its bytes MSB first, then optional XOR beat
   task automatic push_word(input logic [WW-1:0] w);
      logic [7:0] b;
      logic [7:0] x;
      logic       lastf;
      x = '0;
      for (int k = 0; k < NB; k++) begin
         b = 8'((w >> (8 * (NB - 1 - k))) & 24'hFF);
         x = x ^ b;
         lastf = (k == NB - 1) && !CHK_ON;
         expq.push_back({lastf, b});
      end
      if (CHK_ON) expq.push_back({1'b1, x});
   endtask

   // stimulus side: record every accepted word
   always @(negedge clk) begin
      if (rst_n && in_valid && in_ready && !flush)
         push_word(in_word);
   end

   // monitor: compare each handshaken beat against the queue
   always @(negedge clk) begin
      logic [8:0] e;
      if (rst_n) begin
         check("words_sent", words_sent, exp_ws);
         if (IR_load && out_ready) begin
            if (expq.size() == 0) begin
               check("unexpected_beat", payload, 32'hFFFF);
            end else begin
               e = expq.pop_front();
               check("payload", payload, e[7:0]);
               check("out_last", out_last, e[8]);
               if (e[8]) exp_ws = exp_ws + 8'd1;
            end
         end
         if (flush) expq.delete();
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      int n;
      n = 0;
      in_valid = 1'b0;
      flush = 1'b0;
      out_ready = 1'b1;
      while ((IR_load || busy) && n < 200) begin
         step();
         n++;
      end
      check("drain_idle", IR_load, 1'b0);
      step();
      check("queue_empty", expq.size(), 0);
   endtask

   task automatic do_reset();
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      expq.delete();
      exp_ws = '0;
      check("rst_IR_load", IR_load, 1'b0);
      check("rst_payload", payload, 8'h00);
      check("rst_out_last", out_last, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_in_ready", in_ready, 1'b1);
      check("rst_words_sent", words_sent, 8'h00);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int acc;
      // reset values
      #3;
      check("init_IR_load", IR_load, 1'b0);
      check("init_in_ready", in_ready, 1'b1);
      check("init_words_sent", words_sent, 8'h00);
      do_reset();

      // single word, 1-cycle latency, MSB first
      out_ready = 1'b1;
      in_valid = 1'b1;
      in_word = 24'hA1B2C3;
      step();
      in_valid = 1'b0;
      in_word = 24'h000000;
      check("single_b0", payload, 8'hA1);
      check("single_load", IR_load, 1'b1);
      check("single_last0", out_last, 1'b0);
      step();
      check("single_b1", payload, 8'hB2);
      step();
      check("single_b2", payload, 8'hC3);
      check("single_last2", out_last, !CHK_ON);
      if (CHK_ON) begin
         step();
         check("single_chk", payload, 8'hD0);
         check("single_chk_last", out_last, 1'b1);
      end
      step();
      check("single_idle", IR_load, 1'b0);
      check("single_count", words_sent, 8'd1);
      drain();

      // back-to-back words, no bubble
      in_valid = 1'b1;
      in_word = 24'h112233;
      step();
      in_word = 24'h445566;
      for (int k = 0; k < 2 * NBEATS; k++) begin
         check("b2b_no_bubble", IR_load, 1'b1);
         if (k == 1) check("b2b_pend_full", in_ready, 1'b0);
         if (k == NBEATS) check("b2b_pend_free", in_ready, 1'b1);
         step();
         if (k == 0) in_valid = 1'b0;
      end
      check("b2b_end", IR_load, 1'b0);
      drain();

      // backpressure on the middle byte
      in_valid = 1'b1;
      in_word = 24'hA1B2C3;
      step();
      in_valid = 1'b0;
      step();
      out_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         check("bp_payload", payload, 8'hB2);
         check("bp_last", out_last, 1'b0);
         check("bp_load", IR_load, 1'b1);
         step();
      end
      out_ready = 1'b1;
      check("bp_resume_b1", payload, 8'hB2);
      step();
      check("bp_resume_b2", payload, 8'hC3);
      drain();

      // flush with a pending word
      in_valid = 1'b1;
      in_word = 24'hDEADBE;
      step();
      in_word = 24'h777777;
      step();
      in_valid = 1'b0;
      check("fl_pend_full", in_ready, 1'b0);
      acc = int'(words_sent);
      flush = 1'b1;
      in_valid = 1'b1;
      in_word = 24'h555555;
      step();
      flush = 1'b0;
      in_valid = 1'b0;
      check("fl_load", IR_load, 1'b0);
      check("fl_ready", in_ready, 1'b1);
      check("fl_busy", busy, 1'b0);
      check("fl_count", words_sent, acc);
      in_valid = 1'b1;
      in_word = 24'h0A0B0C;
      step();
      in_valid = 1'b0;
      check("fl_restart", payload, 8'h0A);
      drain();

`ifdef IR_CHECKSUM_EN
      // checksum beat
      in_valid = 1'b1;
      in_word = 24'h0F3355;
      step();
      in_valid = 1'b0;
      step();
      step();
      step();
      check("chk_beat", payload, 8'h69);
      check("chk_last", out_last, 1'b1);
      drain();
`endif

      // reset mid-word, then resume
      in_valid = 1'b1;
      in_word = 24'h998877;
      step();
      in_valid = 1'b0;
      do_reset();
      in_valid = 1'b1;
      in_word = 24'h010203;
      step();
      in_valid = 1'b0;
      check("rst_resume_b0", payload, 8'h01);
      drain();

      // randomized traffic with backpressure and occasional flush
      for (int c = 0; c < 1500; c++) begin
         in_valid = ($urandom % 3) != 0;
         in_word = WW'($urandom);
         out_ready = ($urandom % 4) != 0;
         flush = ($urandom % 50) == 0;
         step();
      end
      drain();
      check("rand_count", words_sent, exp_ws);

      // 256 words wrap the counter back to zero
      do_reset();
      n = 0;
      acc = 0;
      out_ready = 1'b1;
      while (acc < 256 && n < 2000) begin
         in_valid = 1'b1;
         in_word = WW'($urandom);
         if (in_ready) acc++;
         step();
         n++;
      end
      check("wrap_accepts", acc, 256);
      drain();
      check("wrap_count", words_sent, 8'h00);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
